// File: rtl/restoring_divider_pkg.sv
// Shared constants and types for the sequential restoring divider.
package restoring_divider_pkg;

    localparam int unsigned DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/restoring_divider_if.sv
// Board-facing bundle of the divider: active-low buttons and switches in, result and flags out.
interface restoring_divider_if
    import restoring_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);
    logic             LoadA;
    logic             LoadB;
    logic             Run;
    logic [WIDTH-1:0] SW;
    logic [WIDTH-1:0] Aval;
    logic [WIDTH-1:0] Bval;
    logic             Busy;
    logic             DivZero;
    logic             Ovf;

    modport master (
        output LoadA, LoadB, Run, SW,
        input  Aval, Bval, Busy, DivZero, Ovf
    );

    modport slave (
        input  LoadA, LoadB, Run, SW,
        output Aval, Bval, Busy, DivZero, Ovf
    );
endinterface

// File: rtl/restoring_divider_div_step.sv
// One shift-compare-subtract step of restoring division on the {A,B} pair.
module restoring_divider_div_step
    import restoring_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] a_next_o,
    output logic [WIDTH-1:0] b_next_o
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] divisor_ext;
    logic           fits;

    // partial = {carry-out of A, shifted A with B's MSB entering}
    always_comb begin
        partial     = {a_i, b_i[WIDTH-1]};
        divisor_ext = {1'b0, d_i};
        fits        = (partial >= divisor_ext);
        if (fits) begin
            a_next_o = WIDTH'(partial - divisor_ext);
        end else begin
            a_next_o = partial[WIDTH-1:0];
        end
        b_next_o = {b_i[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/restoring_divider.sv
// Sequential restoring divider: {Aval,Bval} / D -> quotient in Bval, remainder in Aval.
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic                Clk,
    input  logic                Reset,
    restoring_divider_if.slave  bus
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] step_a;
    logic [WIDTH-1:0] step_b;

    restoring_divider_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a_i      (a_q),
        .b_i      (b_q),
        .d_i      (div_q),
        .a_next_o (step_a),
        .b_next_o (step_b)
    );

    // Next-state and next-output logic; Busy is precomputed so it is high exactly while in CALC.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.LoadA || !bus.LoadB) begin
                    if (!bus.LoadA) a_d = bus.SW;
                    if (!bus.LoadB) b_d = bus.SW;
                end else if (!bus.Run) begin
                    div_d = bus.SW;
                    dz_d  = 1'b0;
                    ovf_d = 1'b0;
                    if (bus.SW == '0) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else if (a_q >= bus.SW) begin
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
            CALC: begin
                a_d   = step_a;
                b_d   = step_b;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                // Wait for Run release so a held button never retriggers.
                if (bus.Run) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.Aval    = a_q;
    assign bus.Bval    = b_q;
    assign bus.Busy    = busy_q;
    assign bus.DivZero = dz_q;
    assign bus.Ovf     = ovf_q;

endmodule
